// File: rtl/dummy_path_sched_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : dummy_path_sched_pkg
// Brief  : Shared types and helpers for the dummy-DRAM path scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package dummy_path_sched_pkg;

  // Scheduler states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_CMD   = 3'd1,
    ST_RD_DRAIN = 3'd2,
    ST_WR_CMD   = 3'd3,
    ST_GAP      = 3'd4
  } sched_state_t;

  // Bursts in one full ORAM path
  function automatic int path_bursts(input int num_buckets, input int bkt_bursts);
    return num_buckets * bkt_bursts;
  endfunction

  // GAP always occupies at least one cycle, even with no idle gap requested
  function automatic int gap_cycles(input int idle_gap);
    return (idle_gap < 1) ? 1 : idle_gap;
  endfunction

endpackage : dummy_path_sched_pkg
`default_nettype wire

// File: rtl/dummy_path_sched_burst_credit_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : dummy_path_sched_burst_credit_tracker
// Brief  : Counts read bursts in flight, retires them as BED chunks return,
//          exposes the next-cycle credit check and flags orphan read data.
// Rev    : 1.0  initial release
// ============================================================================
module dummy_path_sched_burst_credit_tracker #(
  parameter int BST_CHUNKS    = 4,
  parameter int MAX_IN_FLIGHT = 30,
  parameter int IFW           = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           read_fire,
  input  logic           data_valid,
  output logic [IFW-1:0] in_flight,
  output logic           credit_ok,
  output logic           protocol_error
);

  localparam int             CHW        = (BST_CHUNKS > 1) ? $clog2(BST_CHUNKS) : 1;
  localparam logic [CHW-1:0] CHUNK_LAST = CHW'(BST_CHUNKS - 1);
  localparam logic [IFW-1:0] MAX_IF     = IFW'(MAX_IN_FLIGHT);

  logic [CHW-1:0] chunk;
  logic           drop;
  logic           accept;
  logic           retire;
  logic [IFW-1:0] in_flight_d;

  // Classify the incoming chunk and form the next in-flight count.
  // A nonzero chunk count implies at least one burst in flight, so a
  // retire can never underflow.
  always_comb begin
    drop        = data_valid && (in_flight == '0) && (chunk == '0);
    accept      = data_valid && !drop;
    retire      = accept && (chunk == CHUNK_LAST);
    in_flight_d = in_flight;
    if (read_fire && !retire) begin
      in_flight_d = in_flight + 1'b1;
    end else if (!read_fire && retire) begin
      in_flight_d = in_flight - 1'b1;
    end
  end

  // Credit for a command presented next cycle
  assign credit_ok = (in_flight_d < MAX_IF);

  // Chunk counter, in-flight counter and sticky orphan-data flag
  always_ff @(posedge clk) begin
    if (rst) begin
      chunk          <= '0;
      in_flight      <= '0;
      protocol_error <= 1'b0;
    end else begin
      in_flight <= in_flight_d;
      if (accept) begin
        chunk <= retire ? '0 : chunk + 1'b1;
      end
      protocol_error <= (protocol_error && !clear) || drop;
    end
  end

endmodule : dummy_path_sched_burst_credit_tracker
`default_nettype wire

// File: rtl/dummy_path_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : dummy_path_sched
// Brief  : Drives the dummy-DRAM traffic generator as a stand-in ORAM
//          backend: per access, one path of read bursts (credit throttled),
//          drain of returned data, then one path of writeback bursts.
// Rev    : 1.0  initial release
// ============================================================================
module dummy_path_sched
  import dummy_path_sched_pkg::*;
#(
  parameter  int NUM_BUCKETS   = 32,
  parameter  int BKT_BURSTS    = 6,
  parameter  int BST_CHUNKS    = 4,
  parameter  int MAX_IN_FLIGHT = 30,
  parameter  int IDLE_GAP      = 0,
  parameter  int CNT_WIDTH     = 16,
  localparam int PATH_BURSTS   = path_bursts(NUM_BUCKETS, BKT_BURSTS),
  localparam int PW            = $clog2(PATH_BURSTS)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [CNT_WIDTH-1:0] NumAccesses,
  output logic                 Busy,
  output logic                 Done,
  output logic [CNT_WIDTH-1:0] AccessCount,
  output logic                 DRAMCommandValid,
  input  logic                 DRAMCommandReady,
  output logic                 DRAMCommandRead,
  output logic [PW-1:0]        DRAMCommandOffset,
  input  logic                 DRAMReadDataValid,
  output logic                 ProtocolError
);

  localparam int             IFW        = $clog2(MAX_IN_FLIGHT + 1);
  localparam int             GAP_CYC    = gap_cycles(IDLE_GAP);
  localparam int             GW         = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [PW-1:0]  OFF_LAST   = PW'(PATH_BURSTS - 1);
  localparam logic [GW-1:0]  GAP_LAST   = GW'(GAP_CYC - 1);

  sched_state_t         state;
  logic [CNT_WIDTH-1:0] target;
  logic [CNT_WIDTH-1:0] acc_inc;
  logic [GW-1:0]        gap_cnt;
  logic [IFW-1:0]       in_flight;
  logic                 credit_ok;
  logic                 fire;
  logic                 read_fire;
  logic                 run_clear;

  assign fire      = DRAMCommandValid && DRAMCommandReady;
  assign read_fire = fire && (state == ST_RD_CMD);
  assign run_clear = (state == ST_IDLE) && Start;
  assign acc_inc   = AccessCount + 1'b1;

  dummy_path_sched_burst_credit_tracker #(
    .BST_CHUNKS    (BST_CHUNKS),
    .MAX_IN_FLIGHT (MAX_IN_FLIGHT),
    .IFW           (IFW)
  ) u_credit (
    .clk            (Clock),
    .rst            (Reset),
    .clear          (run_clear),
    .read_fire      (read_fire),
    .data_valid     (DRAMReadDataValid),
    .in_flight      (in_flight),
    .credit_ok      (credit_ok),
    .protocol_error (ProtocolError)
  );

  // Sequencer: state, command offset, access counter and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state             <= ST_IDLE;
      target            <= '0;
      gap_cnt           <= '0;
      Busy              <= 1'b0;
      Done              <= 1'b0;
      AccessCount       <= '0;
      DRAMCommandValid  <= 1'b0;
      DRAMCommandRead   <= 1'b0;
      DRAMCommandOffset <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            if (NumAccesses == '0) begin
              Done <= 1'b1;
            end else begin
              target            <= NumAccesses;
              AccessCount       <= '0;
              DRAMCommandOffset <= '0;
              DRAMCommandRead   <= 1'b1;
              Busy              <= 1'b1;
              state             <= ST_RD_CMD;
            end
          end
        end

        ST_RD_CMD: begin
          // Once raised, Valid holds until fired; credit only gates raising it
          if (fire) begin
            if (DRAMCommandOffset == OFF_LAST) begin
              DRAMCommandOffset <= '0;
              DRAMCommandValid  <= 1'b0;
              state             <= ST_RD_DRAIN;
            end else begin
              DRAMCommandOffset <= DRAMCommandOffset + 1'b1;
              DRAMCommandValid  <= credit_ok;
            end
          end else begin
            DRAMCommandValid <= DRAMCommandValid || credit_ok;
          end
        end

        ST_RD_DRAIN: begin
          if (in_flight == '0) begin
            DRAMCommandValid <= 1'b1;
            DRAMCommandRead  <= 1'b0;
            state            <= ST_WR_CMD;
          end
        end

        ST_WR_CMD: begin
          if (fire) begin
            if (DRAMCommandOffset == OFF_LAST) begin
              DRAMCommandOffset <= '0;
              DRAMCommandValid  <= 1'b0;
              AccessCount       <= acc_inc;
              if (acc_inc == target) begin
                Done  <= 1'b1;
                Busy  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                gap_cnt <= '0;
                state   <= ST_GAP;
              end
            end else begin
              DRAMCommandOffset <= DRAMCommandOffset + 1'b1;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            DRAMCommandRead <= 1'b1;
            state           <= ST_RD_CMD;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : dummy_path_sched
`default_nettype wire

// File: tb/tb_dummy_path_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_dummy_path_sched
// Brief  : Directed self-checking bench for dummy_path_sched with a small
//          read-data return model and a cycle monitor.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dummy_path_sched;

  localparam int PB  = 192;
  localparam int MIF = 30;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] NumAccesses;
  logic        Busy;
  logic        Done;
  logic [15:0] AccessCount;
  logic        DRAMCommandValid;
  logic        DRAMCommandReady;
  logic        DRAMCommandRead;
  logic [7:0]  DRAMCommandOffset;
  logic        DRAMReadDataValid;
  logic        ProtocolError;

  logic man_dv = 1'b0;
  logic ret_dv;
  logic ret_en = 1'b0;

  assign DRAMReadDataValid = man_dv | ret_dv;

  always #5 Clock = ~Clock;

  dummy_path_sched #(
    .NUM_BUCKETS   (32),
    .BKT_BURSTS    (6),
    .BST_CHUNKS    (4),
    .MAX_IN_FLIGHT (MIF),
    .IDLE_GAP      (5),
    .CNT_WIDTH     (16)
  ) dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .Start             (Start),
    .NumAccesses       (NumAccesses),
    .Busy              (Busy),
    .Done              (Done),
    .AccessCount       (AccessCount),
    .DRAMCommandValid  (DRAMCommandValid),
    .DRAMCommandReady  (DRAMCommandReady),
    .DRAMCommandRead   (DRAMCommandRead),
    .DRAMCommandOffset (DRAMCommandOffset),
    .DRAMReadDataValid (DRAMReadDataValid),
    .ProtocolError     (ProtocolError)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: counts traffic and records protocol deviations
  int cyc = 0, mon_rd = 0, mon_wr = 0, mon_done = 0, mon_busy = 0, mon_valid = 0;
  int off_err = 0, hold_err = 0, credit_err = 0, gap_err = 0, gap_checks = 0;
  int exp_rd = 0, exp_wr = 0, out_m = 0, chunk_m = 0, last_wr = 0;
  bit gap_armed = 0, prev_hold = 0, prev_read = 0;
  int prev_off = 0;

  always @(negedge Clock) begin
    int out_pre;
    cyc++;
    if (Busy) mon_busy++;
    if (DRAMCommandValid) mon_valid++;
    if (Done) mon_done++;
    if (Reset) begin
      exp_rd = 0; exp_wr = 0; out_m = 0; chunk_m = 0;
      gap_armed = 0; prev_hold = 0;
    end else begin
      out_pre = out_m;
      if (Start) begin
        exp_rd = 0; exp_wr = 0; gap_armed = 0;
      end
      if (prev_hold && !(DRAMCommandValid && int'(DRAMCommandOffset) == prev_off
                         && DRAMCommandRead == prev_read)) hold_err++;
      if (gap_armed && DRAMCommandValid && DRAMCommandRead) begin
        gap_checks++;
        if (cyc - last_wr - 1 < 5) gap_err++;
        gap_armed = 0;
      end
      if (DRAMReadDataValid && !(out_pre == 0 && chunk_m == 0)) begin
        chunk_m++;
        if (chunk_m == 4) begin
          chunk_m = 0;
          out_m--;
        end
      end
      if (DRAMCommandValid && DRAMCommandReady) begin
        if (DRAMCommandRead) begin
          mon_rd++;
          if (int'(DRAMCommandOffset) != exp_rd) off_err++;
          if (out_pre >= MIF) credit_err++;
          out_m++;
          exp_rd = (exp_rd == PB - 1) ? 0 : exp_rd + 1;
        end else begin
          mon_wr++;
          if (int'(DRAMCommandOffset) != exp_wr) off_err++;
          if (exp_wr == PB - 1) begin
            exp_wr = 0; last_wr = cyc; gap_armed = 1;
          end else begin
            exp_wr++;
          end
        end
      end
      prev_hold = DRAMCommandValid && !DRAMCommandReady;
      prev_off  = int'(DRAMCommandOffset);
      prev_read = DRAMCommandRead;
    end
  end

  // Generator model: 4 chunks per read burst, 30 cycles after its fire
  initial begin : ret_gen
    int q[$];
    int c;
    int left;
    c = 0; left = 0; ret_dv = 1'b0;
    forever begin
      @(negedge Clock);
      c++;
      if (ret_en && !Reset && DRAMCommandValid && DRAMCommandReady && DRAMCommandRead)
        q.push_back(c + 30);
      @(posedge Clock);
      #1;
      if (left == 0 && q.size() > 0 && q[0] <= c) begin
        void'(q.pop_front());
        left = 4;
      end
      ret_dv = (left > 0);
      if (left > 0) left--;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic wait_done(input int base, input int budget, input bit rnd, input string tag);
    int n = 0;
    while (mon_done == base && n < budget) begin
      @(posedge Clock);
      #1;
      DRAMCommandReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    chk({tag, " done_in_budget"}, 32'(n < budget), 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " Busy"},   Busy, 0);
    chk({tag, " Done"},   Done, 0);
    chk({tag, " Valid"},  DRAMCommandValid, 0);
    chk({tag, " Read"},   DRAMCommandRead, 0);
    chk({tag, " Offset"}, DRAMCommandOffset, 0);
    chk({tag, " AccCnt"}, AccessCount, 0);
    chk({tag, " PErr"},   ProtocolError, 0);
  endtask

  initial begin
    int r0, w0, d0, b0, v0, oe0, he0, ce0, ge0, gc0;
    Reset = 1'b1; Start = 1'b0; NumAccesses = '0; DRAMCommandReady = 1'b0;
    step(3);
    Reset = 1'b0;
    step(2);
    chk_idle_outputs("reset");

    // T1: start, then reset mid-RD_CMD
    DRAMCommandReady = 1'b1; NumAccesses = 16'd1; Start = 1'b1;
    step(1);
    Start = 1'b0;
    chk("T1 busy_after_start", Busy, 1);
    chk("T1 valid_lat1", DRAMCommandValid, 0);
    step(1);
    chk("T1 valid_lat2", DRAMCommandValid, 1);
    chk("T1 first_offset", DRAMCommandOffset, 0);
    chk("T1 first_read", DRAMCommandRead, 1);
    step(8);
    d0 = mon_done;
    Reset = 1'b1;
    step(1);
    chk_idle_outputs("T1 abort");
    step(2);
    Reset = 1'b0;
    step(3);
    chk("T1 no_done", mon_done - d0, 0);
    chk("T1 busy_idle", Busy, 0);

    // T2: single access with data returned
    r0 = mon_rd; w0 = mon_wr; d0 = mon_done; oe0 = off_err; ce0 = credit_err; he0 = hold_err;
    ret_en = 1'b1; NumAccesses = 16'd1; Start = 1'b1;
    step(1);
    Start = 1'b0;
    wait_done(d0, 5000, 1'b0, "T2");
    step(3);
    chk("T2 reads", mon_rd - r0, PB);
    chk("T2 writes", mon_wr - w0, PB);
    chk("T2 done_pulses", mon_done - d0, 1);
    chk("T2 acc_count", AccessCount, 1);
    chk("T2 perr", ProtocolError, 0);
    chk("T2 busy", Busy, 0);
    chk("T2 offset_errs", off_err - oe0, 0);
    chk("T2 credit_errs", credit_err - ce0, 0);
    chk("T2 hold_errs", hold_err - he0, 0);

    // T4: zero accesses
    d0 = mon_done; b0 = mon_busy; v0 = mon_valid;
    NumAccesses = 16'd0; Start = 1'b1;
    step(1);
    Start = 1'b0;
    chk("T4 done_next", Done, 1);
    step(1);
    chk("T4 done_pulse_end", Done, 0);
    step(5);
    chk("T4 busy_cycles", mon_busy - b0, 0);
    chk("T4 valid_cycles", mon_valid - v0, 0);
    chk("T4 done_pulses", mon_done - d0, 1);

    // T3: credit stall with no returned data
    ret_en = 1'b0; r0 = mon_rd; ce0 = credit_err;
    NumAccesses = 16'd1; Start = 1'b1;
    step(1);
    Start = 1'b0;
    step(100);
    chk("T3 stall_fires", mon_rd - r0, MIF);
    chk("T3 stall_valid", DRAMCommandValid, 0);
    man_dv = 1'b1;
    step(4);
    man_dv = 1'b0;
    step(20);
    chk("T3 release_fires", mon_rd - r0, MIF + 1);
    chk("T3 release_valid", DRAMCommandValid, 0);
    chk("T3 credit_errs", credit_err - ce0, 0);
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    step(2);

    // T5: three accesses, random Ready, idle gap
    ret_en = 1'b1;
    r0 = mon_rd; w0 = mon_wr; d0 = mon_done; oe0 = off_err; ce0 = credit_err;
    he0 = hold_err; ge0 = gap_err; gc0 = gap_checks;
    NumAccesses = 16'd3; Start = 1'b1;
    step(1);
    Start = 1'b0;
    wait_done(d0, 30000, 1'b1, "T5");
    DRAMCommandReady = 1'b1;
    step(3);
    chk("T5 reads", mon_rd - r0, 3 * PB);
    chk("T5 writes", mon_wr - w0, 3 * PB);
    chk("T5 done_pulses", mon_done - d0, 1);
    chk("T5 acc_count", AccessCount, 3);
    chk("T5 gap_checks", gap_checks - gc0, 2);
    chk("T5 gap_errs", gap_err - ge0, 0);
    chk("T5 hold_errs", hold_err - he0, 0);
    chk("T5 offset_errs", off_err - oe0, 0);
    chk("T5 credit_errs", credit_err - ce0, 0);
    chk("T5 perr", ProtocolError, 0);

    // T6: orphan read data in IDLE
    ret_en = 1'b0;
    step(2);
    chk("T6 perr_before", ProtocolError, 0);
    man_dv = 1'b1;
    step(1);
    man_dv = 1'b0;
    chk("T6 perr_set", ProtocolError, 1);
    step(10);
    chk("T6 perr_sticky", ProtocolError, 1);
    chk("T6 busy", Busy, 0);
    NumAccesses = 16'd1; Start = 1'b1;
    step(1);
    Start = 1'b0;
    chk("T6 perr_cleared", ProtocolError, 0);
    chk("T6 busy_run", Busy, 1);
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    step(1);
    chk("T6 busy_after_reset", Busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_dummy_path_sched
`default_nettype wire
